fifo_pacer_reader: RTL and testbench
====================================

// Module: fifo_pacer_reader
// PURPOSE
// Read-side consumer of the dual-clock FIFO in the slow (2 MHz) domain. It pops one
// word at a time, spacing reads by IDLE_CYCLES, and presents each word on rdata.
// It checks that the writer's stream increments by 1 per word (mod 2^DATA_W) and
// counts words received. It pairs with the 99 MHz write-side producer.
// PARAMETERS
// DATA_W       8   FIFO word width
// IDLE_CYCLES  1   idle cycles inserted after each captured word (0 allowed)
// CNT_W        16  width of word_count
// PORTS
// clk         in   1       read-domain clock; the block's only clock
// rst         in   1       reset, asynchronous, active-high
// en          in   1       1 = start new reads; 0 = finish current read, then stop
// fifo_empty  in   1       FIFO rdempty
// fifo_q      in   DATA_W  FIFO q, normal mode (valid the cycle after fifo_req)
// fifo_req    out  1       FIFO rdreq, registered, single-cycle pulse
// rdata       out  DATA_W  last captured word, held until the next capture
// rvalid      out  1       one-cycle pulse when rdata updates
// word_count  out  CNT_W   words captured since reset, wraps at 2^CNT_W
// seq_err     out  1       sticky: a word differed from previous+1
// clr_err     in   1       synchronous clear of seq_err
// BEHAVIOUR
// - One clock (clk). Reset is asynchronous and active-high (rst).
// - Reset values: state=IDLE; fifo_req=0, rvalid=0, rdata=0, word_count=0,
//   seq_err=0, first-word flag=1. All outputs are registered.
// - FSM states: IDLE, REQ, LATCH, HOLD.
//   IDLE : if en && !fifo_empty -> REQ; otherwise stay in IDLE.
//   REQ  : fifo_req=1 for this cycle only -> LATCH.
//   LATCH: capture rdata<=fifo_q; set rvalid=1 on the next cycle; word_count+1;
//          run the sequence check. Then -> IDLE if IDLE_CYCLES==0, else -> HOLD
//          with cnt=IDLE_CYCLES-1.
//   HOLD : if cnt==0 -> IDLE, else cnt-1. The cnt width is $clog2(IDLE_CYCLES+1),
//          minimum 1.
// - Timing: if IDLE sees non-empty at cycle t, fifo_req is 1 at t+1 and rvalid is
//   1 at t+3. With a continuously non-empty FIFO, the fifo_req period is
//   3+IDLE_CYCLES cycles.
// - Only this block pops the FIFO, so fifo_empty cannot go high between the IDLE
//   decision and the REQ pulse. fifo_req is never asserted while fifo_empty=1 in IDLE.
// - en deasserted in REQ, LATCH or HOLD: the current word completes, then the FSM
//   parks in IDLE.
// - Sequence check at capture:
//   - First word after reset: no check; clears the first-word flag.
//   - Later words: error if fifo_q != (prev+1) mod 2^DATA_W. 0xFF->0x00 is legal.
//   - prev is updated to fifo_q on every capture, including erroneous ones.
// - seq_err: set by a mismatch, cleared by clr_err. If both occur in the same
//   cycle, the set wins.
// - word_count wraps to 0 silently.
// - rst during LATCH or HOLD: the popped word is discarded with no recovery;
//   everything returns to reset values; the next word is treated as a first word.
// TESTING
// T1 reset: assert rst mid-stream -> all outputs 0 immediately, no fifo_req until
//    rst=0 and the FIFO is non-empty.
// T2 stream: preload 0x10,0x11,0x12, IDLE_CYCLES=1, en=1 -> fifo_req pulses 4
//    cycles apart; rdata 0x10/0x11/0x12 with rvalid; word_count=3; seq_err=0.
// T3 wrap: words 0xFE,0xFF,0x00 -> seq_err stays 0.
// T4 gap: 0x05,0x07 -> seq_err=1 one cycle after the 0x07 capture. clr_err pulse
//    -> 0. Then clr_err in the same cycle as the mismatch on 0x09 -> seq_err=1.
// T5 en: drop en during REQ with 5 words queued -> exactly 1 word captured, then
//    fifo_req stays 0. Raise en -> reads resume.
// T6 IDLE_CYCLES=0 with continuous data -> fifo_req period 3 cycles, no dropped
//    or duplicated words.

Source files
------------

// File: rtl/fifo_pacer_reader.sv
// Paced read-side consumer of a dual-clock FIFO.
// Pops one word at a time, spaces the reads by IDLE_CYCLES and presents each
// word on rdata with a one-cycle rvalid strobe. It also counts the captured
// words and flags any break in the writer's +1 sequence.
module fifo_pacer_reader #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned IDLE_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              fifo_req,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [CNT_W-1:0]  word_count,
    output logic              seq_err,
    input  logic              clr_err
);

    // The hold counter needs at least one bit, even when no idle gap is used.
    localparam int unsigned HOLD_W = (IDLE_CYCLES == 0) ? 1 : $clog2(IDLE_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD =
        HOLD_W'((IDLE_CYCLES == 0) ? 0 : IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        LATCH = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e              state_q;
    logic [HOLD_W-1:0]   hold_cnt_q;
    logic                first_q;
    logic                fifo_req_q;
    logic                rvalid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [CNT_W-1:0]    word_count_q;
    logic                seq_err_q;
    logic                mismatch_c;

    // rdata_q always holds the previous capture, so it doubles as the
    // reference for the sequence check. The first word after reset is exempt.
    assign mismatch_c = !first_q && (fifo_q != (rdata_q + DATA_W'(1)));

    // Read sequencer: IDLE -> REQ -> LATCH -> (HOLD) -> IDLE, with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            first_q      <= 1'b1;
            fifo_req_q   <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            word_count_q <= '0;
            seq_err_q    <= 1'b0;
        end else begin
            fifo_req_q <= 1'b0;
            rvalid_q   <= 1'b0;

            // A clear is overridden below when a mismatch lands in the same cycle.
            if (clr_err) begin
                seq_err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (en && !fifo_empty) begin
                        state_q    <= REQ;
                        fifo_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    // fifo_q becomes valid during the following cycle.
                    state_q <= LATCH;
                end
                LATCH: begin
                    rdata_q      <= fifo_q;
                    rvalid_q     <= 1'b1;
                    word_count_q <= word_count_q + CNT_W'(1);
                    first_q      <= 1'b0;
                    if (mismatch_c) begin
                        seq_err_q <= 1'b1;
                    end
                    if (IDLE_CYCLES == 0) begin
                        state_q <= IDLE;
                    end else begin
                        state_q    <= HOLD;
                        hold_cnt_q <= HOLD_LOAD;
                    end
                end
                HOLD: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign fifo_req   = fifo_req_q;
    assign rvalid     = rvalid_q;
    assign rdata      = rdata_q;
    assign word_count = word_count_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_fifo_pacer_reader.sv
// Directed bench for fifo_pacer_reader: instance a uses IDLE_CYCLES=1,
// instance b uses IDLE_CYCLES=0. Each instance has its own queue-based FIFO model.
module tb_fifo_pacer_reader;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic clr_err;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a signals and FIFO model
    logic        a_empty;
    logic [7:0]  a_q;
    logic        a_req;
    logic [7:0]  a_rdata;
    logic        a_rvalid;
    logic [15:0] a_cnt;
    logic        a_err;
    logic [7:0]  a_mem[$];
    logic [7:0]  a_cap[$];
    int          a_req_t[$];
    int          a_val_t[$];
    int          a_under = 0;

    // Instance b signals and FIFO model
    logic        b_empty;
    logic [7:0]  b_q;
    logic        b_req;
    logic [7:0]  b_rdata;
    logic        b_rvalid;
    logic [15:0] b_cnt;
    logic        b_err;
    logic [7:0]  b_mem[$];
    logic [7:0]  b_cap[$];
    int          b_req_t[$];
    int          b_under = 0;

    fifo_pacer_reader #(.DATA_W(8), .IDLE_CYCLES(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(a_empty), .fifo_q(a_q),
        .fifo_req(a_req), .rdata(a_rdata), .rvalid(a_rvalid),
        .word_count(a_cnt), .seq_err(a_err), .clr_err(clr_err)
    );

    fifo_pacer_reader #(.DATA_W(8), .IDLE_CYCLES(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(b_empty), .fifo_q(b_q),
        .fifo_req(b_req), .rdata(b_rdata), .rvalid(b_rvalid),
        .word_count(b_cnt), .seq_err(b_err), .clr_err(clr_err)
    );

    // Normal-mode FIFO read port: q updates the edge after rdreq is seen.
    always @(posedge clk) begin
        if (a_req) begin
            if (a_mem.size() > 0) a_q <= a_mem.pop_front();
            else a_under++;
            a_empty = (a_mem.size() == 0);
        end
        if (b_req) begin
            if (b_mem.size() > 0) b_q <= b_mem.pop_front();
            else b_under++;
            b_empty = (b_mem.size() == 0);
        end
    end

    // Record request/valid timing away from the active edge.
    always @(negedge clk) begin
        if (a_req) a_req_t.push_back(cyc);
        if (a_rvalid) begin
            a_cap.push_back(a_rdata);
            a_val_t.push_back(cyc);
        end
        if (b_req) b_req_t.push_back(cyc);
        if (b_rvalid) b_cap.push_back(b_rdata);
    end

    task automatic push_a(input logic [7:0] v);
        a_mem.push_back(v);
        a_empty = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] v);
        b_mem.push_back(v);
        b_empty = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        clr_err = 1'b0;
        #1;
        a_mem.delete(); a_cap.delete(); a_req_t.delete(); a_val_t.delete();
        b_mem.delete(); b_cap.delete(); b_req_t.delete();
        a_empty = 1'b1;
        b_empty = 1'b1;
        a_q = 8'h00;
        b_q = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit seen;
        do_reset();
        total++; if (a_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", a_req); end
        total++; if (a_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", a_rvalid); end
        total++; if (a_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata got=%h want=00", a_rdata); end
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", a_cnt); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_seq_err got=%b want=0", a_err); end
        // Start a stream and hit reset on the first rvalid.
        push_a(8'h20); push_a(8'h21); push_a(8'h22);
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_rvalid) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rst_first_rvalid got=%b want=1", seen); end
        rst = 1'b1;
        #1;
        total++; if (a_rvalid !== 1'b0 || a_req !== 1'b0 || a_err !== 1'b0)
            begin bad++; $display("FAIL rst_async_ctl got=%b%b%b want=000", a_rvalid, a_req, a_err); end
        total++; if (a_rdata !== 8'h00) begin bad++; $display("FAIL rst_async_rdata got=%h want=00", a_rdata); end
        total++; if (a_cnt !== 16'd0) begin bad++; $display("FAIL rst_async_count got=%0d want=0", a_cnt); end
        // Held in reset with a non-empty FIFO: no requests.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (a_req !== 1'b0) begin bad++; $display("FAIL rst_hold_req cyc=%0d got=%b want=0", i, a_req); end
        end
        a_mem.delete();
        a_empty = 1'b1;
        rst = 1'b0;
        // Out of reset but empty: still no requests.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (a_req !== 1'b0) begin bad++; $display("FAIL rst_empty_req cyc=%0d got=%b want=0", i, a_req); end
        end
        // Next word is a first word: no sequence error whatever its value.
        push_a(8'h77);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_rvalid) begin seen = 1'b1; break; end
        end
        total++; if (seen !== 1'b1 || a_rdata !== 8'h77)
            begin bad++; $display("FAIL rst_resume got=%b/%h want=1/77", seen, a_rdata); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL rst_resume_err got=%b want=0", a_err); end
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL rst_resume_count got=%0d want=1", a_cnt); end
    endtask

    task automatic test_stream();
        int c0;
        do_reset();
        push_a(8'h10); push_a(8'h11); push_a(8'h12);
        c0 = cyc;
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_cnt == 16'd3) break;
        end
        repeat (6) @(negedge clk);
        total++; if (a_cnt !== 16'd3) begin bad++; $display("FAIL stream_count got=%0d want=3", a_cnt); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL stream_err got=%b want=0", a_err); end
        total++; if (a_req_t.size() != 3) begin bad++; $display("FAIL stream_nreq got=%0d want=3", a_req_t.size()); end
        total++; if (a_cap.size() != 3) begin bad++; $display("FAIL stream_ncap got=%0d want=3", a_cap.size()); end
        if (a_req_t.size() == 3 && a_val_t.size() == 3) begin
            total++; if (a_req_t[0] != c0 + 1) begin bad++; $display("FAIL stream_req_lat got=%0d want=%0d", a_req_t[0], c0 + 1); end
            total++; if (a_val_t[0] != c0 + 3) begin bad++; $display("FAIL stream_val_lat got=%0d want=%0d", a_val_t[0], c0 + 3); end
            for (int i = 1; i < 3; i++) begin
                total++; if (a_req_t[i] - a_req_t[i-1] != 4)
                    begin bad++; $display("FAIL stream_period idx=%0d got=%0d want=4", i, a_req_t[i] - a_req_t[i-1]); end
            end
        end
        for (int i = 0; i < a_cap.size() && i < 3; i++) begin
            total++; if (a_cap[i] !== 8'(8'h10 + i))
                begin bad++; $display("FAIL stream_data idx=%0d got=%h want=%h", i, a_cap[i], 8'(8'h10 + i)); end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        push_a(8'hFE); push_a(8'hFF); push_a(8'h00);
        en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (a_cnt == 16'd3) break;
        end
        total++; if (a_cnt !== 16'd3) begin bad++; $display("FAIL wrap_count got=%0d want=3", a_cnt); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL wrap_err got=%b want=0", a_err); end
        total++; if (a_rdata !== 8'h00) begin bad++; $display("FAIL wrap_rdata got=%h want=00", a_rdata); end
    endtask

    task automatic test_gap();
        int nv;
        bit seen;
        do_reset();
        push_a(8'h05); push_a(8'h07);
        en = 1'b1;
        nv = 0;
        for (int i = 0; i < 40 && nv < 2; i++) begin
            @(negedge clk);
            if (a_rvalid) begin
                nv++;
                if (nv == 1) begin
                    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL gap_err_first got=%b want=0", a_err); end
                end else begin
                    total++; if (a_err !== 1'b1 || a_rdata !== 8'h07)
                        begin bad++; $display("FAIL gap_err_set got=%b/%h want=1/07", a_err, a_rdata); end
                end
            end
        end
        total++; if (nv != 2) begin bad++; $display("FAIL gap_captures got=%0d want=2", nv); end
        // Sticky until cleared.
        repeat (3) @(negedge clk);
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL gap_sticky got=%b want=1", a_err); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL gap_clear got=%b want=0", a_err); end
        // Clear held through the mismatching capture of 0x09: set wins.
        repeat (2) @(negedge clk);
        clr_err = 1'b1;
        push_a(8'h09);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_rvalid) begin seen = 1'b1; break; end
        end
        clr_err = 1'b0;
        total++; if (seen !== 1'b1 || a_rdata !== 8'h09)
            begin bad++; $display("FAIL gap_09_capture got=%b/%h want=1/09", seen, a_rdata); end
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL gap_set_wins got=%b want=1", a_err); end
        @(negedge clk);
        total++; if (a_err !== 1'b1) begin bad++; $display("FAIL gap_set_hold got=%b want=1", a_err); end
    endtask

    task automatic test_en();
        do_reset();
        for (int i = 0; i < 5; i++) push_a(8'(8'h30 + i));
        en = 1'b1;
        @(negedge clk);
        total++; if (a_req !== 1'b1) begin bad++; $display("FAIL en_in_req got=%b want=1", a_req); end
        en = 1'b0;
        repeat (20) @(negedge clk);
        total++; if (a_cnt !== 16'd1) begin bad++; $display("FAIL en_one_word got=%0d want=1", a_cnt); end
        total++; if (a_req_t.size() != 1) begin bad++; $display("FAIL en_nreq got=%0d want=1", a_req_t.size()); end
        total++; if (a_rdata !== 8'h30) begin bad++; $display("FAIL en_rdata got=%h want=30", a_rdata); end
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (a_cnt == 16'd5) break;
        end
        total++; if (a_cnt !== 16'd5) begin bad++; $display("FAIL en_resume_count got=%0d want=5", a_cnt); end
        total++; if (a_err !== 1'b0) begin bad++; $display("FAIL en_resume_err got=%b want=0", a_err); end
        for (int i = 0; i < a_cap.size() && i < 5; i++) begin
            total++; if (a_cap[i] !== 8'(8'h30 + i))
                begin bad++; $display("FAIL en_data idx=%0d got=%h want=%h", i, a_cap[i], 8'(8'h30 + i)); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) push_b(8'(8'h40 + i));
        en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (b_cnt == 16'd8) break;
        end
        repeat (4) @(negedge clk);
        total++; if (b_cnt !== 16'd8) begin bad++; $display("FAIL b2b_count got=%0d want=8", b_cnt); end
        total++; if (b_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", b_err); end
        total++; if (b_under != 0) begin bad++; $display("FAIL b2b_underflow got=%0d want=0", b_under); end
        total++; if (b_req_t.size() != 8) begin bad++; $display("FAIL b2b_nreq got=%0d want=8", b_req_t.size()); end
        total++; if (b_cap.size() != 8) begin bad++; $display("FAIL b2b_ncap got=%0d want=8", b_cap.size()); end
        for (int i = 1; i < b_req_t.size(); i++) begin
            total++; if (b_req_t[i] - b_req_t[i-1] != 3)
                begin bad++; $display("FAIL b2b_period idx=%0d got=%0d want=3", i, b_req_t[i] - b_req_t[i-1]); end
        end
        for (int i = 0; i < b_cap.size() && i < 8; i++) begin
            total++; if (b_cap[i] !== 8'(8'h40 + i))
                begin bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", i, b_cap[i], 8'(8'h40 + i)); end
        end
        total++; if (a_under != 0) begin bad++; $display("FAIL a_underflow got=%0d want=0", a_under); end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        clr_err = 1'b0;
        a_empty = 1'b1;
        b_empty = 1'b1;
        a_q = 8'h00;
        b_q = 8'h00;
        test_reset();
        test_stream();
        test_wrap();
        test_gap();
        test_en();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
